dmem_arbiter: RTL

Shares the single data-memory port between two requesters: port 0 is the core's load/store path, port 1 is the program loader/debug path. Grants one transaction at a time, tracks the single outstanding read until its data returns after a fixed memory latency, and raises a stall to the core's PC/pipeline logic while a port-0 access is blocked or pending. Sits between the core datapath and the data memory.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter_arb_pick.sv | 47 ++++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int unsigned FUNCT_BITS = 3;
  localparam int unsigned LAT_W      = 2;

  localparam logic [FUNCT_BITS-1:0] FUNCT_B  = 3'b000;
  localparam logic [FUNCT_BITS-1:0] FUNCT_H  = 3'b001;
  localparam logic [FUNCT_BITS-1:0] FUNCT_W  = 3'b010;
  localparam logic [FUNCT_BITS-1:0] FUNCT_BU = 3'b100;
  localparam logic [FUNCT_BITS-1:0] FUNCT_HU = 3'b101;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req0,   req1;
  logic          we0,    we1;
  logic [2:0]    funct0, funct1;
  logic [AW-1:0] addr0,  addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0,   gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [2:0]    mem_funct;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cpu_stall;

  modport slave (
    input  req0, req1, we0, we1, funct0, funct1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_en, mem_we, mem_funct, mem_addr, mem_wdata,
    input  mem_rdata,
    output cpu_stall
  );

  modport master (
    output req0, req1, we0, we1, funct0, funct1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_en, mem_we, mem_funct, mem_addr, mem_wdata,
    output mem_rdata,
    input  cpu_stall
  );
endinterface

// File: rtl/dmem_arbiter_arb_pick.sv
// Two-way winner select. DMEM_ARB_RR_EN: round-robin on ties using a
// last-grant register; otherwise fixed priority with port 0 winning.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic win_c
);

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    win_c  = PORT_CPU;
    last_d = last_q;
    if (req0 && req1) begin
      win_c = (last_q == PORT_LDR) ? PORT_CPU : PORT_LDR;
    end else if (req1) begin
      win_c = PORT_LDR;
    end
    if (grant_en) begin
      last_d = win_c;
    end
  end

  // Reset to port 1 so the first tie goes to the core.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= PORT_LDR;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = ^{clk, reset, grant_en, req1};

  always_comb begin
    win_c = req0 ? PORT_CPU : PORT_LDR;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Single data-memory port shared by the core (port 0) and loader (port 1).
// Optional round-robin tie-break enabled by defining DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic          win;
  logic          rd_done;
  logic          can_grant;
  logic          grant;
  logic          win_we;
  logic [2:0]    win_funct;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  arb_pick u_pick (
    .clk      (clk),
    .reset    (reset),
    .req0     (bus.req0),
    .req1     (bus.req1),
    .grant_en (grant),
    .win_c    (win)
  );

  // Issue / return decision; all outputs forced low while reset is held.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.rvalid0  = 1'b0;
    bus.rvalid1  = 1'b0;
    bus.rdata0   = '0;
    bus.rdata1   = '0;
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_funct = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_stall = 1'b0;

    win_we    = (win == PORT_LDR) ? bus.we1    : bus.we0;
    win_funct = (win == PORT_LDR) ? bus.funct1 : bus.funct0;
    win_addr  = (win == PORT_LDR) ? bus.addr1  : bus.addr0;
    win_wdata = (win == PORT_LDR) ? bus.wdata1 : bus.wdata0;

    rd_done   = (state_q == RD_WAIT) && (lat_cnt_q == '0);
    can_grant = (state_q == IDLE) || rd_done;
    grant     = reset && can_grant && (bus.req0 || bus.req1);

    if ((state_q == RD_WAIT) && !rd_done) begin
      lat_cnt_d = lat_cnt_q - LAT_W'(1);
    end

    if (rd_done) begin
      state_d = IDLE;
      if (reset) begin
        if (owner_q == PORT_CPU) begin
          bus.rvalid0 = 1'b1;
          bus.rdata0  = bus.mem_rdata;
        end else begin
          bus.rvalid1 = 1'b1;
          bus.rdata1  = bus.mem_rdata;
        end
      end
    end

    if (grant) begin
      bus.gnt0      = (win == PORT_CPU);
      bus.gnt1      = (win == PORT_LDR);
      bus.mem_en    = 1'b1;
      bus.mem_we    = win_we;
      bus.mem_funct = win_funct;
      bus.mem_addr  = win_addr;
      bus.mem_wdata = win_wdata;
      if (!win_we) begin
        state_d   = RD_WAIT;
        owner_d   = win;
        lat_cnt_d = LAT_W'(MEM_LAT - 1);
      end
    end

    bus.cpu_stall = reset &&
                    ((bus.req0 && !bus.gnt0) ||
                     ((state_q == RD_WAIT) && (owner_q == PORT_CPU) && !bus.rvalid0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= PORT_CPU;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule
